// File: rtl/run_ctrl.sv
// Run controller: sequences core reset/enable around a host-requested run,
// counts RUN cycles with a timeout, and arbitrates the data-memory port.
module run_ctrl #(
  parameter int          CW   = 16,
  parameter int unsigned TMO  = 16'd60000,
  parameter int          HOLD = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          core_done,
  output logic          core_rst,
  output logic          core_en,
  input  logic          host_req,
  input  logic          host_wr_en,
  input  logic [7:0]    host_addr,
  input  logic [7:0]    host_dat,
  output logic          host_gnt,
  input  logic          core_wr_en,
  input  logic [7:0]    core_addr,
  input  logic [7:0]    core_dat,
  output logic          mem_wr_en,
  output logic [7:0]    mem_addr,
  output logic [7:0]    mem_dat,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, PRE, RUN, FIN} state_t;

  state_t        state, nxt;
  logic [HW-1:0] hold_cnt;
  logic          hold_last, at_tmo;

  assign hold_last = (hold_cnt == HW'(HOLD - 1));
  assign at_tmo    = (cycles == CW'(TMO - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req) nxt = PRE;
      PRE:  if (!req) nxt = IDLE; else if (hold_last) nxt = RUN;
      RUN:  if (!req) nxt = IDLE; else if (core_done || at_tmo) nxt = FIN;
      FIN:  if (!req) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    core_rst = 1'b0;
    core_en  = 1'b0;
    busy     = 1'b0;
    host_gnt = 1'b0;
    case (state)
      IDLE: begin core_rst = 1'b1; host_gnt = host_req; end
      PRE:  begin core_rst = 1'b1; busy = 1'b1; end
      RUN:  begin core_en = 1'b1; busy = 1'b1; end
      FIN:  host_gnt = host_req;
      default: core_rst = 1'b1;
    endcase
  end

  // Abort wins over completion; the terminating RUN cycle never increments,
  // so cycles tops out at TMO-1 and cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      cycles   <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          timeout <= 1'b0;
          if (req) begin
            hold_cnt <= '0;
            cycles   <= '0;
          end
        end
        PRE:  hold_cnt <= hold_cnt + 1'b1;
        RUN: begin
          if (req) begin
            if (core_done)   done    <= 1'b1;
            else if (at_tmo) timeout <= 1'b1;
            else             cycles  <= cycles + 1'b1;
          end
        end
        FIN: begin
          if (!req) begin
            done    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // core_en gates core stores so they only reach memory during RUN.
  always_comb begin
    if (host_gnt) begin
      mem_wr_en = host_wr_en;
      mem_addr  = host_addr;
      mem_dat   = host_dat;
    end else begin
      mem_wr_en = core_wr_en & core_en;
      mem_addr  = core_addr;
      mem_dat   = core_dat;
    end
  end

endmodule
